bpsk_soft_demapper: RTL
=======================

// Module: bpsk_soft_demapper
// PURPOSE
// - Streaming BPSK soft demapper: inverse of the PUCCH BPSK mapper. Mapping is
//   b=0 -> (+0x5A82,+0x5A82), b=1 -> (0xA57E,0xA57E), sfix16 Q1.15.
// - Converts each equalised IQ sample (sfix16 re/im) into a signed LLR, a hard
//   bit and a frame-last flag.
// - Sits between the PUCCH equaliser output and the UCI decoder.
// - Two-stage pipeline with valid/ready flow control on both sides.
// PARAMETERS
// - LLR_W    default 8   LLR output width, signed, symmetric saturation
// - FRAME_W  default 8   width of frame-length and beat counter
// PORTS
// - i_clk         in   1        clock; single clock domain
// - i_rst_n       in   1        synchronous reset, active-low
// - i_valid       in   1        input sample valid
// - o_ready       out  1        demapper can accept a sample this cycle
// - i_re          in   16       sfix16 in-phase sample
// - i_im          in   16       sfix16 quadrature sample
// - i_llr_shift   in   3        right-shift applied to (re+im) before saturation
// - i_frame_len   in   FRAME_W  beats per frame; 0 is treated as 1
// - o_valid       out  1        output beat valid
// - i_ready       in   1        downstream accepts the beat
// - o_llr         out  LLR_W    signed LLR; positive means bit 0 more likely
// - o_bit         out  1        hard decision
// - o_sat         out  1        o_llr was clipped for this beat
// - o_last        out  1        last beat of the current frame
// BEHAVIOUR
// - Reset (i_rst_n=0 at a clock edge): all registers clear; o_valid=0,
//   o_llr=0, o_bit=0, o_sat=0, o_last=0, beat counter=0. o_ready=1 from the
//   first cycle after reset.
// - Reset mid-frame discards both pipeline stages and the frame position.
//   The next accepted sample starts a new frame.
// - Handshakes: input transfer on i_valid&&o_ready; output transfer on
//   o_valid&&i_ready. Per stage, ready_k = !valid_k || ready_{k+1}.
//   o_ready = stage-1 ready. Throughput is 1 sample/cycle. No combinational
//   path from i_valid to o_valid.
// - Latency: 2 cycles from input transfer to o_valid when i_ready is held
//   high.
// - While a beat is stalled (o_valid && !i_ready), o_llr, o_bit, o_sat and
//   o_last stay stable.
// - Stage 1: registers sum = sext17(i_re) + sext17(i_im), 17 bits, no overflow
//   possible. i_llr_shift is captured with the sample.
// - Stage 2: t = (sum + (shift ? 1<<(shift-1) : 0)) >>> shift (arithmetic
//   shift, round-half-up). t is clipped to +/-(2^(LLR_W-1)-1); the value
//   -2^(LLR_W-1) is never emitted. o_sat=1 iff clipping occurred.
// - o_bit = 1 iff sum < 0. sum == 0 gives o_bit=0 and o_llr=0.
// - Frame counter: advances on output transfer only.
//   - frame_len is latched on the first output transfer of each frame.
//   - o_last = (cnt == len_latched-1), using the latched value (on the first
//     beat, the value being latched).
//   - After the last transfer, cnt wraps to 0.
//   - Changing i_frame_len mid-frame takes effect from the next frame.
// - Simultaneous events: input and output transfer in the same cycle with a
//   full pipeline is legal and loses no data.
// STRUCTURE
// - Shared package nr_pucch_pkg holds:
//   - IQ_W=16
//   - BPSK_AMP=16'h5A82 and BPSK_AMP_N=16'hA57E
//   - typedef iq_t {logic signed [15:0] re, im;}
//   - LLR saturation function sat_llr(sum, shift, w)
// - One sub-module, pipe_reg_stage: a parameterised valid/ready register
//   slice, instantiated twice. The datapath and frame counter stay in the
//   top level.
// TESTING
// - Ideal points, shift=7, LLR_W=8:
//   - (5A82,5A82) -> sum=46340, t=362, o_llr=+127, o_sat=1, o_bit=0.
//   - (A57E,A57E) -> o_llr=-127, o_sat=1, o_bit=1.
// - Small values, shift=2:
//   - re=3, im=2 -> sum=5, o_llr=+1, o_bit=0.
//   - re=-3, im=-3 -> sum=-6, o_llr=-1 (rounding), o_bit=1.
//   - re=1, im=-1 -> o_llr=0, o_bit=0.
// - Framing: frame_len=4, 10 back-to-back samples, i_ready=1 ->
//   - o_last on beats 3 and 7.
//   - Beats 8 and 9 pending with cnt=2.
//   - Output begins 2 cycles after the first input.
// - Backpressure: i_ready toggles in a random 30% duty pattern ->
//   - 1000 samples out, matching the golden model in order.
//   - No drop or duplicate.
//   - Output stable while stalled.
//   - o_ready falls only when both stages are full and i_ready=0.
// - Reset mid-frame: frame_len=5, reset after 3 beats ->
//   - o_valid=0 the next cycle.
//   - The next frame's o_last is on its 5th beat.
// - frame_len=0 -> every beat has o_last=1.

Source files
------------

// File: rtl/nr_pucch_pkg.sv
// ---------------------------------------------------------------------------
// nr_pucch_pkg
// Shared PUCCH definitions used by the BPSK soft demapper.
//   IQ_W        sample width of the equalised re/im components (sfix16 Q1.15)
//   SUM_W       width of re+im, one guard bit so the sum can never overflow
//   BPSK_AMP    constellation amplitude for b=0 (+1/sqrt(2) in Q1.15)
//   BPSK_AMP_N  constellation amplitude for b=1 (-1/sqrt(2) in Q1.15)
//   iq_t        one complex sample
//   s1_t        payload held by the first pipeline stage
//   llr_sat_t   result of the LLR scaling/saturation helper
//   sat_llr()   round, shift and symmetrically clip a sum to a w-bit LLR
// ---------------------------------------------------------------------------
package nr_pucch_pkg;

    localparam int IQ_W    = 16;
    localparam int SUM_W   = IQ_W + 1;
    localparam int SHIFT_W = 3;

    localparam logic [IQ_W-1:0] BPSK_AMP   = 16'h5A82;
    localparam logic [IQ_W-1:0] BPSK_AMP_N = 16'hA57E;

    typedef struct packed {
        logic signed [IQ_W-1:0] re;
        logic signed [IQ_W-1:0] im;
    } iq_t;

    typedef struct packed {
        logic signed [SUM_W-1:0] sum;
        logic [SHIFT_W-1:0]      shift;
    } s1_t;

    typedef struct packed {
        logic                    sat;
        logic signed [SUM_W-1:0] val;
    } llr_sat_t;

    // Round-half-up arithmetic right shift of sum, then clip to
    // +/-(2^(w-1)-1). The most negative w-bit code is never produced, so the
    // LLR range is symmetric around zero. Valid for 2 <= w <= SUM_W.
    function automatic llr_sat_t sat_llr(
        input logic signed [SUM_W-1:0] sum,
        input logic [SHIFT_W-1:0]      shift,
        input int                      w
    );
        int       s_v;
        int       rnd_v;
        int       t_v;
        int       lim_v;
        llr_sat_t res_v;
        s_v   = int'(sum);
        rnd_v = (shift == 3'd0) ? 32'sd0 : (32'sd1 <<< (int'(shift) - 32'sd1));
        t_v   = (s_v + rnd_v) >>> shift;
        lim_v = (32'sd1 <<< (w - 32'sd1)) - 32'sd1;
        if (t_v > lim_v) begin
            res_v.sat = 1'b1;
            t_v       = lim_v;
        end else if (t_v < -lim_v) begin
            res_v.sat = 1'b1;
            t_v       = -lim_v;
        end else begin
            res_v.sat = 1'b0;
        end
        res_v.val = t_v[SUM_W-1:0];
        return res_v;
    endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// ---------------------------------------------------------------------------
// pipe_reg_stage
// One valid/ready register slice. The slice accepts a new word whenever it
// is empty or its current word leaves this cycle, which gives full
// throughput with a single register and a combinational ready path back
// towards the producer. Payload and valid are both registered.
// Ports:
//   clk       clock
//   rst_n     synchronous reset, active-low (clears valid and payload)
//   up_valid  producer has a word
//   up_ready  slice can take a word this cycle
//   up_data   producer payload, W bits
//   dn_valid  slice holds a word
//   dn_ready  consumer takes the word this cycle
//   dn_data   registered payload, W bits
// ---------------------------------------------------------------------------
module pipe_reg_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);

    logic         valid_r;
    logic [W-1:0] data_r;

    assign up_ready = !valid_r || dn_ready;
    assign dn_valid = valid_r;
    assign dn_data  = data_r;

    // Slice register: reload when free or draining, otherwise hold the word
    // so the consumer sees a stable payload while it stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (up_ready) begin
            valid_r <= up_valid;
            if (up_valid) begin
                data_r <= up_data;
            end
        end
    end

endmodule

// File: rtl/bpsk_soft_demapper.sv
// ---------------------------------------------------------------------------
// bpsk_soft_demapper
// Streaming soft demapper for the PUCCH BPSK constellation
// b=0 -> (+A,+A), b=1 -> (-A,-A). Projecting a sample on the (1,1) axis
// gives re+im, which is the LLR up to scale: positive favours b=0.
// Stage 1 registers the 17-bit sum with its shift amount, stage 2 registers
// the scaled/saturated LLR, hard bit and clip flag. A beat counter tags the
// last beat of every frame as beats leave the block.
// Ports:
//   i_clk        clock
//   i_rst_n      synchronous reset, active-low
//   i_valid      input sample valid
//   o_ready      a sample can be accepted this cycle
//   i_re, i_im   sfix16 equalised sample
//   i_llr_shift  right shift applied to re+im before saturation
//   i_frame_len  beats per frame (0 behaves as 1)
//   o_valid      output beat valid
//   i_ready      downstream accepts the beat
//   o_llr        signed LLR, symmetric saturation to LLR_W bits
//   o_bit        hard decision (1 iff re+im < 0)
//   o_sat        o_llr was clipped
//   o_last       beat is the last of its frame
// ---------------------------------------------------------------------------
import nr_pucch_pkg::*;

module bpsk_soft_demapper #(
    parameter int LLR_W   = 8,
    parameter int FRAME_W = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [IQ_W-1:0]         i_re,
    input  logic [IQ_W-1:0]         i_im,
    input  logic [SHIFT_W-1:0]      i_llr_shift,
    input  logic [FRAME_W-1:0]      i_frame_len,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic signed [LLR_W-1:0] o_llr,
    output logic                    o_bit,
    output logic                    o_sat,
    output logic                    o_last
);

    localparam int S1_W = SUM_W + SHIFT_W;
    localparam int S2_W = LLR_W + 2;

    iq_t                     iq_s;
    s1_t                     s1_in_s;
    s1_t                     s1_out_s;
    logic [S1_W-1:0]         s1_bits_s;
    logic                    s1_valid_s;
    logic                    s2_ready_s;
    llr_sat_t                llr_res_s;
    logic signed [LLR_W-1:0] llr_s;
    logic                    bit_s;
    logic [S2_W-1:0]         s2_in_s;
    logic [S2_W-1:0]         s2_out_s;

    logic [FRAME_W-1:0]      cnt_r;
    logic [FRAME_W-1:0]      len_r;
    logic [FRAME_W-1:0]      eff_len_s;
    logic [FRAME_W-1:0]      cur_len_s;
    logic                    hit_last_s;
    logic                    out_xfer_s;

    assign iq_s.re = i_re;
    assign iq_s.im = i_im;

    // Stage-1 payload: both components sign-extended to 17 bits before the
    // add, so the sum of two full-scale values cannot wrap.
    always_comb begin
        s1_in_s.sum   = {iq_s.re[IQ_W-1], iq_s.re} + {iq_s.im[IQ_W-1], iq_s.im};
        s1_in_s.shift = i_llr_shift;
    end

    pipe_reg_stage #(
        .W (S1_W)
    ) u_stage1 (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .up_valid (i_valid),
        .up_ready (o_ready),
        .up_data  (s1_in_s),
        .dn_valid (s1_valid_s),
        .dn_ready (s2_ready_s),
        .dn_data  (s1_bits_s)
    );

    assign s1_out_s = s1_bits_s;

    // Stage-2 payload: scaled/clipped LLR, sign of the sum as hard bit and
    // the clip flag. A zero sum yields bit 0 and LLR 0 naturally.
    always_comb begin
        llr_res_s = sat_llr(s1_out_s.sum, s1_out_s.shift, LLR_W);
        llr_s     = LLR_W'(llr_res_s.val);
        bit_s     = s1_out_s.sum[SUM_W-1];
        s2_in_s   = {llr_s, bit_s, llr_res_s.sat};
    end

    pipe_reg_stage #(
        .W (S2_W)
    ) u_stage2 (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .up_valid (s1_valid_s),
        .up_ready (s2_ready_s),
        .up_data  (s2_in_s),
        .dn_valid (o_valid),
        .dn_ready (i_ready),
        .dn_data  (s2_out_s)
    );

    assign o_llr = s2_out_s[S2_W-1:2];
    assign o_bit = s2_out_s[1];
    assign o_sat = s2_out_s[0];

    // Frame length for the beat at the head of the output: a new frame uses
    // the live length (it is latched as that beat leaves), later beats use
    // the latched copy so mid-frame changes only affect the next frame.
    always_comb begin
        if (i_frame_len == {FRAME_W{1'b0}}) begin
            eff_len_s = FRAME_W'(1'b1);
        end else begin
            eff_len_s = i_frame_len;
        end
        if (cnt_r == {FRAME_W{1'b0}}) begin
            cur_len_s = eff_len_s;
        end else begin
            cur_len_s = len_r;
        end
        hit_last_s = (cnt_r == (cur_len_s - FRAME_W'(1'b1)));
    end

    assign out_xfer_s = o_valid && i_ready;
    assign o_last     = o_valid && hit_last_s;

    // Beat counter: moves only when a beat actually leaves, wraps after the
    // last beat of a frame, and latches the frame length on the first beat.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_r <= {FRAME_W{1'b0}};
            len_r <= {FRAME_W{1'b0}};
        end else if (out_xfer_s) begin
            if (cnt_r == {FRAME_W{1'b0}}) begin
                len_r <= eff_len_s;
            end
            if (hit_last_s) begin
                cnt_r <= {FRAME_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + FRAME_W'(1'b1);
            end
        end
    end

endmodule
